// File: rtl/namuru_accum_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// namuru_accum_scheduler_pkg
//   Shared definitions for the accumulator readout scheduler:
//   - FSM state encoding (IDLE / ARB / REQ / DONE)
//   - default channel count, channel index width and readout timeout
//   The optional readout timeout is enabled by defining ACCUM_SCHED_TIMEOUT_EN.
//   It is undefined by default.
// -----------------------------------------------------------------------------
package namuru_accum_scheduler_pkg;

  localparam int NUM_CHAN_DEF = 12;
  localparam int CHAN_W_DEF   = 4;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/namuru_rr_pick.sv
// -----------------------------------------------------------------------------
// namuru_rr_pick
//   Combinational round-robin picker for a shared resource.
//   The search starts at last_i+1 and wraps modulo NUM_CHAN (not 2^CHAN_W).
//   It returns the first pending requester it finds.
//   Ports:
//     pending_i [NUM_CHAN]  requesters still waiting for service
//     last_i    [CHAN_W]    index granted most recently (must be < NUM_CHAN)
//     valid_o               at least one requester is pending
//     index_o   [CHAN_W]    chosen requester; 0 when valid_o is low
// -----------------------------------------------------------------------------
module namuru_rr_pick #(
  parameter int NUM_CHAN = 12,
  parameter int CHAN_W   = 4
) (
  input  logic [NUM_CHAN-1:0] pending_i,
  input  logic [CHAN_W-1:0]   last_i,
  output logic                valid_o,
  output logic [CHAN_W-1:0]   index_o
);

  // One extra bit so last+offset (< 2*NUM_CHAN) never overflows before the wrap
  logic [CHAN_W:0] cand_s;

  // Walk the offsets from farthest to nearest so the nearest pending requester wins
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand_s  = '0;
    for (int i = NUM_CHAN; i >= 1; i--) begin
      cand_s = {1'b0, last_i} + (CHAN_W+1)'(i);
      if (cand_s >= (CHAN_W+1)'(NUM_CHAN)) begin
        cand_s = cand_s - (CHAN_W+1)'(NUM_CHAN);
      end else begin
        cand_s = cand_s;
      end
      if (pending_i[cand_s[CHAN_W-1:0]]) begin
        valid_o = 1'b1;
        index_o = cand_s[CHAN_W-1:0];
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/namuru_accum_scheduler.sv
// -----------------------------------------------------------------------------
// namuru_accum_scheduler
//   Sequences accumulator readout after each accum_enable pulse.
//   The dump flags are snapshotted when the pulse arrives. The shared readout path
//   is then granted to one channel at a time in round-robin order. Each serviced
//   flag is cleared, and a sticky interrupt is raised for the host.
//   Optional macro ACCUM_SCHED_TIMEOUT_EN adds a readout timeout and the
//   timeout_err output.
//   Ports:
//     sys_clk, sys_rst        clock, synchronous active-high reset
//     accum_enable            one-cycle pulse: start a dump round
//     dump_flag  [NUM_CHAN]   level, channel holds a fresh dump
//     rd_req / rd_chan        readout request and granted channel
//     rd_ack                  readout done for rd_chan
//     dump_clr   [NUM_CHAN]   one-hot 1-cycle pulse clearing the serviced flag
//     status     [NUM_CHAN]   sticky: channels read since the last status_clr
//     status_clr              host clear for status/irq/overrun/timeout_err
//     irq, overrun, busy      sticky round-done irq, sticky overrun, not-IDLE
//     timeout_err             (ACCUM_SCHED_TIMEOUT_EN only) sticky readout timeout
// -----------------------------------------------------------------------------
module namuru_accum_scheduler
  import namuru_accum_scheduler_pkg::*;
#(
  parameter int NUM_CHAN = NUM_CHAN_DEF,
  parameter int CHAN_W   = CHAN_W_DEF
`ifdef ACCUM_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                accum_enable,
  input  logic [NUM_CHAN-1:0] dump_flag,
  output logic                rd_req,
  output logic [CHAN_W-1:0]   rd_chan,
  input  logic                rd_ack,
  output logic [NUM_CHAN-1:0] dump_clr,
  output logic [NUM_CHAN-1:0] status,
  input  logic                status_clr,
  output logic                irq,
  output logic                overrun,
  output logic                busy
`ifdef ACCUM_SCHED_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  sched_state_e        state_q, state_d;
  logic [NUM_CHAN-1:0] pending_q, pending_d;
  logic [CHAN_W-1:0]   last_q, last_d;
  logic                rd_req_q, rd_req_d;
  logic [CHAN_W-1:0]   rd_chan_q, rd_chan_d;
  logic [NUM_CHAN-1:0] dump_clr_q, dump_clr_d;
  logic [NUM_CHAN-1:0] status_q, status_d;
  logic                irq_q, irq_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                round_rd_q, round_rd_d;   // some channel was read this round

  logic [NUM_CHAN-1:0] status_set_s;
  logic                irq_set_s;
  logic                overrun_set_s;
  logic                pick_valid_s;
  logic [CHAN_W-1:0]   pick_idx_s;

`ifdef ACCUM_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic                tmo_set_s;
`endif

  namuru_rr_pick #(
    .NUM_CHAN (NUM_CHAN),
    .CHAN_W   (CHAN_W)
  ) u_rr_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .valid_o   (pick_valid_s),
    .index_o   (pick_idx_s)
  );

  // Next-state and output decode for the readout sequencer
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    last_d        = last_q;
    rd_req_d      = rd_req_q;
    rd_chan_d     = rd_chan_q;
    dump_clr_d    = '0;
    round_rd_d    = round_rd_q;
    status_set_s  = '0;
    irq_set_s     = 1'b0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    tmo_set_s     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accum_enable) begin
          pending_d  = dump_flag;
          round_rd_d = 1'b0;
          state_d    = ST_ARB;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (pick_valid_s) begin
          rd_chan_d = pick_idx_s;
          rd_req_d  = 1'b1;
          state_d   = ST_REQ;
`ifdef ACCUM_SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          state_d   = ST_DONE;
        end
      end
      ST_REQ: begin
        if (rd_ack) begin
          rd_req_d                = 1'b0;
          dump_clr_d[rd_chan_q]   = 1'b1;
          pending_d[rd_chan_q]    = 1'b0;
          status_set_s[rd_chan_q] = 1'b1;
          last_d                  = rd_chan_q;
          round_rd_d              = 1'b1;
          state_d                 = ST_ARB;
`ifdef ACCUM_SCHED_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // Give up on this channel: it is neither cleared nor reported as read
          rd_req_d             = 1'b0;
          pending_d[rd_chan_q] = 1'b0;
          last_d               = rd_chan_q;
          tmo_set_s            = 1'b1;
          state_d              = ST_ARB;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          state_d   = ST_REQ;
`else
        end else begin
          state_d = ST_REQ;
`endif
        end
      end
      ST_DONE: begin
        irq_set_s = round_rd_q;
        state_d   = ST_IDLE;
      end
      default: begin
        rd_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // DONE still counts as busy, so a pulse there is an overrun and starts nothing
    overrun_set_s = accum_enable && (state_q != ST_IDLE);

    // Sticky flags: a set in the same cycle as status_clr wins
    status_d  = (status_q & ~{NUM_CHAN{status_clr}}) | status_set_s;
    irq_d     = irq_set_s | (irq_q & ~status_clr);
    overrun_d = overrun_set_s | (overrun_q & ~status_clr);
`ifdef ACCUM_SCHED_TIMEOUT_EN
    tmo_err_d = tmo_set_s | (tmo_err_q & ~status_clr);
`endif
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      last_q     <= CHAN_W'(NUM_CHAN - 1);
      rd_req_q   <= 1'b0;
      rd_chan_q  <= '0;
      dump_clr_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      round_rd_q <= 1'b0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
      rd_req_q   <= rd_req_d;
      rd_chan_q  <= rd_chan_d;
      dump_clr_q <= dump_clr_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
      round_rd_q <= round_rd_d;
`ifdef ACCUM_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  assign rd_req   = rd_req_q;
  assign rd_chan  = rd_chan_q;
  assign dump_clr = dump_clr_q;
  assign status   = status_q;
  assign irq      = irq_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;
`ifdef ACCUM_SCHED_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`endif

endmodule
